// File: rtl/prbs7_ber_monitor_if.sv
// Control/status bundle between the PRBS7 BER monitor and its slow-control host.
interface prbs7_ber_monitor_if #(
    parameter int unsigned ACC_WIDTH = 48
) ();
    logic                 enable;
    logic                 clear;
    logic [5:0]           errorCount;
    logic                 locked;
    logic [ACC_WIDTH-1:0] errAcc;
    logic [ACC_WIDTH-1:0] wordAcc;
    logic [7:0]           lolCount;
    logic                 errSticky;

    // Host side: drives word stream and controls, reads statistics.
    modport master (
        output enable, clear, errorCount,
        input  locked, errAcc, wordAcc, lolCount, errSticky
    );

    // Monitor side.
    modport slave (
        input  enable, clear, errorCount,
        output locked, errAcc, wordAcc, lolCount, errSticky
    );
endinterface

// File: rtl/prbs7_ber_monitor.sv
// PRBS7 lock detector and BER accumulator fed by the checker's per-word error count.
module prbs7_ber_monitor #(
    parameter int unsigned LOCK_CYCLES = 64,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned ACC_WIDTH   = 48
) (
    input logic                 clk,
    input logic                 rst,
    prbs7_ber_monitor_if.slave  bus
);
    localparam int unsigned GW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned BW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [0:0] StUnlocked = 1'b0;
    localparam logic [0:0] StLocked   = 1'b1;

    localparam logic [GW:0] LockTarget   = LOCK_CYCLES[GW:0];
    localparam logic [BW:0] UnlockTarget = UNLOCK_ERRS[BW:0];

    logic [0:0]           state_q, state_d;
    logic [GW-1:0]        good_q, good_d;
    logic [BW-1:0]        bad_q, bad_d;
    logic [ACC_WIDTH-1:0] err_q, err_d;
    logic [ACC_WIDTH-1:0] word_q, word_d;
    logic [7:0]           lol_q, lol_d;
    logic                 sticky_q, sticky_d;

    logic                 word_bad;
    logic [GW:0]          good_inc;
    logic [BW:0]          bad_inc;
    logic [ACC_WIDTH:0]   err_sum;
    logic [ACC_WIDTH:0]   word_sum;

    // Run increments and one-bit-wider sums; the extra MSB is the saturation carry.
    always_comb begin
        word_bad = (bus.errorCount != 6'd0);
        good_inc = {1'b0, good_q} + {{GW{1'b0}}, 1'b1};
        bad_inc  = {1'b0, bad_q} + {{BW{1'b0}}, 1'b1};
        err_sum  = {1'b0, err_q} + {{(ACC_WIDTH - 5){1'b0}}, bus.errorCount};
        word_sum = {1'b0, word_q} + {{ACC_WIDTH{1'b0}}, 1'b1};
    end

    // Next-state: lock FSM, run counters, saturating statistics; clear overrides stats.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = err_q;
        word_d   = word_q;
        lol_d    = lol_q;
        sticky_d = sticky_q;

        if (bus.enable) begin
            if (state_q == StUnlocked) begin
                if (word_bad) begin
                    good_d = '0;
                end else if (good_inc == LockTarget) begin
                    state_d = StLocked;
                    good_d  = '0;
                    bad_d   = '0;
                end else begin
                    good_d = good_inc[GW-1:0];
                end
            end else begin
                word_d = word_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : word_sum[ACC_WIDTH-1:0];
                err_d  = err_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : err_sum[ACC_WIDTH-1:0];
                if (word_bad) begin
                    sticky_d = 1'b1;
                    if (bad_inc == UnlockTarget) begin
                        state_d = StUnlocked;
                        good_d  = '0;
                        bad_d   = '0;
                        lol_d   = (lol_q == 8'hff) ? lol_q : lol_q + 8'd1;
                    end else begin
                        bad_d = bad_inc[BW-1:0];
                    end
                end else begin
                    bad_d = '0;
                end
            end
        end

        // Clear ignores enable and beats any same-cycle update, including loss-of-lock.
        if (bus.clear) begin
            err_d    = '0;
            word_d   = '0;
            lol_d    = '0;
            sticky_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StUnlocked;
            good_q   <= '0;
            bad_q    <= '0;
            err_q    <= '0;
            word_q   <= '0;
            lol_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            word_q   <= word_d;
            lol_q    <= lol_d;
            sticky_q <= sticky_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        bus.locked    = (state_q == StLocked);
        bus.errAcc    = err_q;
        bus.wordAcc   = word_q;
        bus.lolCount  = lol_q;
        bus.errSticky = sticky_q;
    end
endmodule

// File: tb/tb_prbs7_ber_monitor.sv
// Bench for prbs7_ber_monitor: a 48-bit instance plus an 8-bit shadow for saturation.
module tb_prbs7_ber_monitor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prbs7_ber_monitor_if #(.ACC_WIDTH(48)) bus_w ();
    prbs7_ber_monitor_if #(.ACC_WIDTH(8))  bus_n ();

    prbs7_ber_monitor #(.LOCK_CYCLES(64), .UNLOCK_ERRS(4), .ACC_WIDTH(48)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    prbs7_ber_monitor #(.LOCK_CYCLES(64), .UNLOCK_ERRS(4), .ACC_WIDTH(8)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    typedef struct {
        logic            en;
        logic            clr;
        logic [5:0]      ec;
        int              n;
        logic            lk;
        longint unsigned err;
        longint unsigned word;
        int              lol;
        logic            st;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs to both instances for n edges; sample 1 time unit after the last edge.
    task automatic run(input logic en, input logic clr, input logic [5:0] ec, input int n);
        for (int k = 0; k < n; k++) begin
            bus_w.enable = en; bus_w.clear = clr; bus_w.errorCount = ec;
            bus_n.enable = en; bus_n.clear = clr; bus_n.errorCount = ec;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_w(input string tag, input logic lk, input longint unsigned err,
                         input longint unsigned word, input int lol, input logic st);
        chk({tag, ".locked"},    64'(bus_w.locked),    64'(lk));
        chk({tag, ".errAcc"},    bus_w.errAcc,         err);
        chk({tag, ".wordAcc"},   bus_w.wordAcc,        word);
        chk({tag, ".lolCount"},  64'(bus_w.lolCount),  64'(lol));
        chk({tag, ".errSticky"}, 64'(bus_w.errSticky), 64'(st));
    endtask

    task automatic chk_n(input string tag, input logic lk, input longint unsigned err,
                         input longint unsigned word, input logic st);
        chk({tag, ".n_locked"},    64'(bus_n.locked),    64'(lk));
        chk({tag, ".n_errAcc"},    64'(bus_n.errAcc),    err);
        chk({tag, ".n_wordAcc"},   64'(bus_n.wordAcc),   word);
        chk({tag, ".n_errSticky"}, 64'(bus_n.errSticky), 64'(st));
    endtask

    initial begin
        //                  en clr ec  n    lk err word lol st
        tbl.push_back('{1'b1, 1'b0, 6'd0,  63, 1'b0,  0,  0, 0, 1'b0}); // one short of lock
        tbl.push_back('{1'b1, 1'b0, 6'd0,   1, 1'b1,  0,  0, 0, 1'b0}); // 64th locks, not counted
        tbl.push_back('{1'b1, 1'b0, 6'd0,  10, 1'b1,  0, 10, 0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 6'd3,   1, 1'b1,  3, 11, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd0,   1, 1'b1,  3, 12, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd5,   1, 1'b1,  8, 13, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd0,   1, 1'b1,  8, 14, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd1,   3, 1'b1, 11, 17, 0, 1'b1}); // 3 of 4 bad
        tbl.push_back('{1'b1, 1'b0, 6'd1,   1, 1'b0, 12, 18, 1, 1'b1}); // loss word counted
        tbl.push_back('{1'b1, 1'b0, 6'd0,  63, 1'b0, 12, 18, 1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd0,   1, 1'b1, 12, 18, 1, 1'b1}); // relock
        tbl.push_back('{1'b1, 1'b0, 6'd2,   4, 1'b0, 20, 22, 2, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'd0,   1, 1'b0,  0,  0, 0, 1'b0}); // clear while disabled
        tbl.push_back('{1'b1, 1'b0, 6'd0,  63, 1'b0,  0,  0, 0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 6'd2,   1, 1'b0,  0,  0, 0, 1'b0}); // run restarts
        tbl.push_back('{1'b1, 1'b0, 6'd0,  63, 1'b0,  0,  0, 0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 6'd0,   1, 1'b1,  0,  0, 0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 6'd7,  20, 1'b1,  0,  0, 0, 1'b0}); // disabled: hold
        tbl.push_back('{1'b1, 1'b0, 6'd1,   3, 1'b1,  3,  3, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 6'd1,   1, 1'b0,  0,  0, 0, 1'b0}); // clear beats loss
        tbl.push_back('{1'b1, 1'b0, 6'd0,  64, 1'b1,  0,  0, 0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 6'd9,   3, 1'b1, 27,  3, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd0,   1, 1'b1, 27,  4, 0, 1'b1}); // badRun reset
        tbl.push_back('{1'b1, 1'b0, 6'd9,   3, 1'b1, 54,  7, 0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 6'd40,  1, 1'b0, 94,  8, 1, 1'b1}); // illegal value, as-is

        rst = 1'b1;
        run(1'b0, 1'b0, 6'd0, 2);
        rst = 1'b0;
        chk_w("reset", 1'b0, 0, 0, 0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].en, tbl[i].clr, tbl[i].ec, tbl[i].n);
            chk_w($sformatf("row%0d", i), tbl[i].lk, tbl[i].err, tbl[i].word, tbl[i].lol,
                  tbl[i].st);
        end

        // Saturation on the 8-bit instance; both are unlocked with goodRun=0 here.
        run(1'b1, 1'b0, 6'd0, 64);
        run(1'b1, 1'b1, 6'd0, 1);               // clear beats the word increment
        chk_n("sat_clr", 1'b1, 0, 0, 1'b0);
        for (int p = 0; p < 7; p++) begin
            run(1'b1, 1'b0, 6'd32, 1);
            run(1'b1, 1'b0, 6'd0, 1);
        end
        chk_n("sat7", 1'b1, 224, 14, 1'b1);
        run(1'b1, 1'b0, 6'd32, 1);
        run(1'b1, 1'b0, 6'd0, 1);
        chk_n("sat8", 1'b1, 255, 16, 1'b1);
        for (int p = 0; p < 2; p++) begin
            run(1'b1, 1'b0, 6'd32, 1);
            run(1'b1, 1'b0, 6'd0, 1);
        end
        chk_n("sat10", 1'b1, 255, 20, 1'b1);
        chk_w("wide10", 1'b1, 320, 20, 0, 1'b1);
        run(1'b0, 1'b1, 6'd5, 1);
        chk_n("sat_clr2", 1'b1, 0, 0, 1'b0);
        run(1'b1, 1'b0, 6'd0, 300);
        chk_n("wsat", 1'b1, 0, 255, 1'b0);
        chk_w("wide300", 1'b1, 0, 300, 0, 1'b0);

        // Reset while locked, with enabled errored input pending.
        rst = 1'b1;
        run(1'b1, 1'b0, 6'd5, 1);
        rst = 1'b0;
        chk_w("rst_lock", 1'b0, 0, 0, 0, 1'b0);
        chk_n("rst_lock", 1'b0, 0, 0, 1'b0);
        run(1'b1, 1'b0, 6'd0, 1);
        chk_w("post_rst", 1'b0, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
